button_event_classifier: RTL and testbench



---
 rtl/button_event_classifier.sv | 170 +++++++++++++++++
 tb/tb_button_event_classifier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into short, long and double presses.
// Emits registered one-cycle event pulses, a held indicator and an event counter.

package pipeline_types;
    typedef struct packed {
        logic rising;
        logic falling;
    } control_path_t;
endpackage

module button_event_classifier #(
    parameter int unsigned LONG_PRESS_CYCLES = 1000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 300,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_level,
    input  pipeline_types::control_path_t i_control,
    output logic                          o_short_press,
    output logic                          o_long_press,
    output logic                          o_double_press,
    output logic                          o_held,
    output logic [7:0]                    o_event_count
);

    localparam int unsigned EVT_W     = 8;
    localparam int unsigned MAX_PARAM = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ?
                                        LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    if (LONG_PRESS_CYCLES < 2 || DOUBLE_GAP_CYCLES < 2 || CNT_WIDTH < 1 ||
        (CNT_WIDTH < 32 && (64'd1 << CNT_WIDTH) <= 64'(MAX_PARAM))) begin : g_bad_params
        $error("button_event_classifier: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_GAP,
        S_SECOND_PRESS
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_next_cnt;
    logic                   r_stale;
    logic                   w_next_stale;
    logic                   r_short;
    logic                   r_long;
    logic                   r_double;
    logic                   r_held;
    logic [EVT_W-1:0]       r_event_count;
    logic                   w_short;
    logic                   w_long;
    logic                   w_double;
    logic                   w_rise;
    logic                   w_fall;

    // Coincident edges cancel each other out.
    assign w_rise = i_control.rising  & ~i_control.falling;
    assign w_fall = i_control.falling & ~i_control.rising;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stale <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_stale <= w_next_stale;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_stale = r_stale;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_double     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_cnt = '0;
                // A level seen high without its rising edge belongs to a press we missed.
                if (w_fall) begin
                    w_next_stale = 1'b0;
                end else if (i_level && !w_rise) begin
                    w_next_stale = 1'b1;
                end
                if (w_rise && !r_stale) begin
                    w_next_state = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (w_fall) begin
                    w_next_state = S_WAIT_GAP;
                    w_next_cnt   = '0;
                end else if (r_cnt == LONG_LAST) begin
                    w_next_state = S_LONG_HELD;
                    w_long       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_LONG_HELD: begin
                if (w_fall) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end
            end
            S_WAIT_GAP: begin
                if (w_rise) begin
                    w_next_state = S_SECOND_PRESS;
                    w_next_cnt   = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                    w_short      = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_SECOND_PRESS: begin
                if (w_fall) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                    w_double     = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Output registers: pulses appear the cycle after the triggering edge or timeout.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_short       <= 1'b0;
            r_long        <= 1'b0;
            r_double      <= 1'b0;
            r_held        <= 1'b0;
            r_event_count <= '0;
        end else begin
            r_short       <= w_short;
            r_long        <= w_long;
            r_double      <= w_double;
            r_held        <= (w_next_state == S_LONG_HELD);
            r_event_count <= r_event_count + EVT_W'(w_short | w_long | w_double);
        end
    end

    assign o_short_press  = r_short;
    assign o_long_press   = r_long;
    assign o_double_press = r_double;
    assign o_held         = r_held;
    assign o_event_count  = r_event_count;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=4.
module tb_button_event_classifier;

    logic                          i_clk;
    logic                          i_reset_n;
    logic                          i_level;
    pipeline_types::control_path_t ctl;
    logic                          o_short_press;
    logic                          o_long_press;
    logic                          o_double_press;
    logic                          o_held;
    logic [7:0]                    o_event_count;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] P_NONE   = 3'b000;
    localparam logic [2:0] P_SHORT  = 3'b100;
    localparam logic [2:0] P_LONG   = 3'b010;
    localparam logic [2:0] P_DOUBLE = 3'b001;

    button_event_classifier #(
        .LONG_PRESS_CYCLES(8),
        .DOUBLE_GAP_CYCLES(4),
        .CNT_WIDTH        (16)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_level       (i_level),
        .i_control     (ctl),
        .o_short_press (o_short_press),
        .o_long_press  (o_long_press),
        .o_double_press(o_double_press),
        .o_held        (o_held),
        .o_event_count (o_event_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive edges/level, clock, then sample pulses and held.
    task automatic step(input logic r, input logic f, input logic l,
                        input logic [2:0] ep, input logic eh, input string tag);
        ctl.rising  = r;
        ctl.falling = f;
        i_level     = l;
        @(posedge i_clk);
        #1;
        check({tag, "_pulses"}, 32'({o_short_press, o_long_press, o_double_press}), 32'(ep));
        check({tag, "_held"}, 32'(o_held), 32'(eh));
    endtask

    task automatic quiet(input int n, input logic l, input logic eh, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, l, P_NONE, eh, tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pulses"}, 32'({o_short_press, o_long_press, o_double_press}), 32'(0));
        check({tag, "_held"}, 32'(o_held), 32'(0));
        check({tag, "_count"}, 32'(o_event_count), 32'(0));
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_level     = 1'b0;
        ctl.rising  = 1'b0;
        ctl.falling = 1'b0;
        #1;
        check_zero_outputs("reset_state");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        quiet(3, 1'b0, 1'b0, "post_reset_idle");

        // Short press: rise t0, fall t0+3, short seen after tick t0+7.
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "sp_rise");
        quiet(2, 1'b1, 1'b0, "sp_hold");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "sp_fall");
        quiet(3, 1'b0, 1'b0, "sp_gap");
        step(1'b0, 1'b0, 1'b0, P_SHORT, 1'b0, "sp_event");
        check("sp_count", 32'(o_event_count), 32'd1);
        quiet(3, 1'b0, 1'b0, "sp_after");

        // Long press: long pulse after tick t0+8, held until the falling edge.
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "lp_rise");
        quiet(7, 1'b1, 1'b0, "lp_pressed");
        step(1'b0, 1'b0, 1'b1, P_LONG, 1'b1, "lp_event");
        quiet(11, 1'b1, 1'b1, "lp_held");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "lp_fall");
        quiet(6, 1'b0, 1'b0, "lp_after");
        check("lp_count", 32'(o_event_count), 32'd2);

        // Double press: rise t0, fall t0+2, rise t0+4, fall t0+10.
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "dp_rise1");
        quiet(1, 1'b1, 1'b0, "dp_hold1");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "dp_fall1");
        quiet(1, 1'b0, 1'b0, "dp_gap");
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "dp_rise2");
        quiet(5, 1'b1, 1'b0, "dp_hold2");
        step(1'b0, 1'b1, 1'b0, P_DOUBLE, 1'b0, "dp_event");
        quiet(6, 1'b0, 1'b0, "dp_after");
        check("dp_count", 32'(o_event_count), 32'd3);

        // Falling on the long threshold cycle takes the short path.
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "bl_rise");
        quiet(7, 1'b1, 1'b0, "bl_pressed");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "bl_fall_on_thresh");
        quiet(3, 1'b0, 1'b0, "bl_gap");
        step(1'b0, 1'b0, 1'b0, P_SHORT, 1'b0, "bl_short");
        quiet(2, 1'b0, 1'b0, "bl_after");
        check("bl_count", 32'(o_event_count), 32'd4);

        // Rising on the gap timeout cycle takes the double path.
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "bg_rise1");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "bg_fall1");
        quiet(3, 1'b0, 1'b0, "bg_gap");
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "bg_rise_on_timeout");
        quiet(2, 1'b1, 1'b0, "bg_hold2");
        step(1'b0, 1'b1, 1'b0, P_DOUBLE, 1'b0, "bg_double");
        quiet(6, 1'b0, 1'b0, "bg_after");
        check("bg_count", 32'(o_event_count), 32'd5);

        // Simultaneous rising+falling in IDLE is ignored.
        step(1'b1, 1'b1, 1'b0, P_NONE, 1'b0, "sim_edges");
        quiet(12, 1'b0, 1'b0, "sim_after");
        check("sim_count", 32'(o_event_count), 32'd5);

        // Async reset in LONG_HELD, then button still held across reset release.
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "rl_rise");
        quiet(7, 1'b1, 1'b0, "rl_pressed");
        step(1'b0, 1'b0, 1'b1, P_LONG, 1'b1, "rl_long");
        check("rl_count_pre", 32'(o_event_count), 32'd6);
        quiet(2, 1'b1, 1'b1, "rl_held");
        #2 i_reset_n = 1'b0;
        #1;
        check_zero_outputs("rl_async_reset");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        quiet(6, 1'b1, 1'b0, "rl_held_through_reset");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "rl_release");
        quiet(8, 1'b0, 1'b0, "rl_after_release");
        check("rl_count_post", 32'(o_event_count), 32'd0);
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "rl_new_rise");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "rl_new_fall");
        quiet(3, 1'b0, 1'b0, "rl_new_gap");
        step(1'b0, 1'b0, 1'b0, P_SHORT, 1'b0, "rl_new_short");
        check("rl_new_count", 32'(o_event_count), 32'd1);

        // Async reset in WAIT_GAP drops the pending short press.
        step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "rg_rise");
        step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "rg_fall");
        quiet(1, 1'b0, 1'b0, "rg_gap");
        #2 i_reset_n = 1'b0;
        #1;
        check_zero_outputs("rg_async_reset");
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        quiet(10, 1'b0, 1'b0, "rg_after");
        check("rg_count", 32'(o_event_count), 32'd0);

        // 256 short presses wrap the event counter back to zero.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 1'b1, P_NONE, 1'b0, "wrap_rise");
            step(1'b0, 1'b1, 1'b0, P_NONE, 1'b0, "wrap_fall");
            quiet(3, 1'b0, 1'b0, "wrap_gap");
            step(1'b0, 1'b0, 1'b0, P_SHORT, 1'b0, "wrap_short");
            check("wrap_count", 32'(o_event_count), 32'((i + 1) % 256));
        end
        quiet(2, 1'b0, 1'b0, "wrap_after");
        check("wrap_final", 32'(o_event_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
